// File: rtl/keypad_entry_fsm.sv
// rtl/keypad_entry_fsm.sv - keypad operand/operator entry FSM feeding the arithmetic core
//
// Purpose:
//   Builds BCD operands digit by digit from scanner keycodes, latches the operator,
//   and hands {operand_a, op, operand_b} to the arithmetic core over valid/ready.
//   The live entry buffer drives the 7-seg display path.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   keycode      in   4-bit key value, sampled only when keypressed=1
//   keypressed   in   one-cycle key strobe
//   calc_valid   out  operands/op valid to arithmetic core
//   calc_ready   in   arithmetic core ready
//   operand_a    out  first operand, BCD, MS digit in top nibble
//   operand_b    out  second operand, BCD
//   op           out  00 add, 01 sub, 10 mul
//   entry        out  current entry buffer, BCD
//   entry_count  out  digits held in entry (0..DIGITS)
//   second_op    out  high while entering operand B
//   overflow     out  one-cycle pulse when a digit is rejected on a full buffer
module keypad_entry_fsm #(
  parameter int         DIGITS   = 4,
  parameter logic [3:0] KEY_ADD  = 4'hA,
  parameter logic [3:0] KEY_SUB  = 4'hB,
  parameter logic [3:0] KEY_MUL  = 4'hF,
  parameter logic [3:0] KEY_CLR  = 4'hC,
  parameter logic [3:0] KEY_BKSP = 4'hD,
  parameter logic [3:0] KEY_EQ   = 4'hE
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [3:0]                     keycode,
  input  logic                           keypressed,
  output logic                           calc_valid,
  input  logic                           calc_ready,
  output logic [4*DIGITS-1:0]            operand_a,
  output logic [4*DIGITS-1:0]            operand_b,
  output logic [1:0]                     op,
  output logic [4*DIGITS-1:0]            entry,
  output logic [$clog2(DIGITS+1)-1:0]    entry_count,
  output logic                           second_op,
  output logic                           overflow
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ISSUE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [1:0]    op_q, op_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic          is_digit;
  logic          is_op;
  logic [1:0]    key_op;

  always_comb begin
    is_digit = (keycode <= 4'd9);
    is_op    = (keycode == KEY_ADD) || (keycode == KEY_SUB) || (keycode == KEY_MUL);
    key_op   = 2'b00;
    if (keycode == KEY_SUB) key_op = 2'b01;
    if (keycode == KEY_MUL) key_op = 2'b10;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ENTER_A;
      entry_q <= '0;
      count_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= 2'b00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;

    case (state_q)
      ENTER_A, ENTER_B: begin
        if (keypressed) begin
          if (is_digit) begin
            if (count_q == FULL) begin
              ovf_d = 1'b1;
            end else if (!(count_q == '0 && keycode == 4'd0)) begin
              // Leading zeros are dropped so the buffer always holds a canonical value.
              entry_d = (entry_q << 4) | W'(keycode);
              count_d = count_q + CW'(1);
            end
          end else if (keycode == KEY_BKSP) begin
            if (count_q != '0) begin
              entry_d = entry_q >> 4;
              count_d = count_q - CW'(1);
            end
          end else if (keycode == KEY_CLR) begin
            entry_d = '0;
            count_d = '0;
            if (state_q == ENTER_B) begin
              opa_d   = '0;
              op_d    = 2'b00;
              state_d = ENTER_A;
            end
          end else if (is_op) begin
            if (state_q == ENTER_A) begin
              opa_d   = entry_q;
              op_d    = key_op;
              entry_d = '0;
              count_d = '0;
              state_d = ENTER_B;
            end else if (count_q == '0) begin
              // Operator change is allowed only before any B digit is typed.
              op_d = key_op;
            end
          end else if (keycode == KEY_EQ && state_q == ENTER_B) begin
            opb_d   = entry_q;
            valid_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Keys are ignored here; only the handshake moves the machine on.
        if (valid_q && calc_ready) begin
          valid_d = 1'b0;
          entry_d = '0;
          count_d = '0;
          state_d = ENTER_A;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  assign calc_valid  = valid_q;
  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign op          = op_q;
  assign entry       = entry_q;
  assign entry_count = count_q;
  assign second_op   = (state_q == ENTER_B);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_entry_fsm.sv
// tb/tb_keypad_entry_fsm.sv - scoreboard bench for keypad_entry_fsm
module tb_keypad_entry_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  keycode = 4'h0;
  logic        keypressed = 1'b0;
  logic        calc_valid;
  logic        calc_ready = 1'b0;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [1:0]  op;
  logic [15:0] entry;
  logic [2:0]  entry_count;
  logic        second_op;
  logic        overflow;

  keypad_entry_fsm dut (
    .clock       (clock),
    .reset       (reset),
    .keycode     (keycode),
    .keypressed  (keypressed),
    .calc_valid  (calc_valid),
    .calc_ready  (calc_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op          (op),
    .entry       (entry),
    .entry_count (entry_count),
    .second_op   (second_op),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] entry;
    int          cnt;
    bit          sec;
    bit          ovf;
    bit          vld;
    logic [15:0] a;
    logic [1:0]  op;
    logic [15:0] b;
  } snap_t;

  typedef struct {
    logic [15:0] a;
    logic [1:0]  op;
    logic [15:0] b;
  } txn_t;

  snap_t snap_q[$];
  txn_t  txn_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: entry held as a plain decimal value; mode 0=A, 1=B, 2=issuing.
  int mval = 0;
  int mmode = 0;
  int ma = 0;
  int mop = 0;
  int mb = 0;

  bit mon_en = 1'b0;
  bit kp_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ndig(input int v);
    int n = 0;
    while (v > 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic logic [15:0] bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int opcode_of(input int k);
    if (k == 11) return 1;
    if (k == 15) return 2;
    return 0;
  endfunction

  task automatic press(input int k);
    snap_t s;
    bit ovf = 1'b0;
    if (mmode != 2) begin
      if (k <= 9) begin
        if (ndig(mval) == 4) ovf = 1'b1;
        else mval = mval * 10 + k;
      end else if (k == 13) begin
        mval = mval / 10;
      end else if (k == 12) begin
        mval = 0;
        if (mmode == 1) begin
          ma = 0;
          mop = 0;
          mmode = 0;
        end
      end else if (k == 10 || k == 11 || k == 15) begin
        if (mmode == 0) begin
          ma = mval;
          mop = opcode_of(k);
          mval = 0;
          mmode = 1;
        end else if (mval == 0) begin
          mop = opcode_of(k);
        end
      end else if (k == 14 && mmode == 1) begin
        txn_t t;
        mb = mval;
        t.a = bcd(ma);
        t.op = 2'(mop);
        t.b = bcd(mb);
        txn_q.push_back(t);
        mmode = 2;
      end
    end
    s.entry = bcd(mval);
    s.cnt   = ndig(mval);
    s.sec   = (mmode == 1);
    s.ovf   = ovf;
    s.vld   = (mmode == 2);
    s.a     = bcd(ma);
    s.op    = 2'(mop);
    s.b     = bcd(mb);
    snap_q.push_back(s);
    keycode = 4'(k);
    keypressed = 1'b1;
    @(posedge clock); #1;
    keypressed = 1'b0;
    keycode = 4'(($urandom_range(0, 15)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic accept(input int hold);
    for (int i = 0; i < hold; i++) begin
      if ($urandom_range(0, 1) == 1) press($urandom_range(0, 15));
      else idle(1);
    end
    calc_ready = 1'b1;
    @(posedge clock); #1;
    calc_ready = 1'b0;
    mval = 0;
    mmode = 0;
  endtask

  always @(posedge clock) kp_prev <= keypressed;

  // Monitor: compares visible state after every key, and the issued transaction
  // every cycle calc_valid is up, popping it on the handshake cycle.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (kp_prev) begin
        if (snap_q.size() == 0) begin
          chk("snap_underflow", 32'd1, 32'd0);
        end else begin
          snap_t s;
          s = snap_q.pop_front();
          chk("entry", entry, s.entry);
          chk("entry_count", entry_count, s.cnt);
          chk("second_op", second_op, s.sec);
          chk("overflow", overflow, s.ovf);
          chk("calc_valid", calc_valid, s.vld);
          chk("operand_a", operand_a, s.a);
          chk("op", op, s.op);
          chk("operand_b", operand_b, s.b);
        end
      end else begin
        chk("overflow_idle", overflow, 1'b0);
      end
      if (calc_valid) begin
        if (txn_q.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          chk("txn_a", operand_a, txn_q[0].a);
          chk("txn_op", op, txn_q[0].op);
          chk("txn_b", operand_b, txn_q[0].b);
          if (calc_ready) void'(txn_q.pop_front());
        end
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1;
    idle(2);
    chk("reset_outputs", {calc_valid, operand_a, operand_b, op}, 35'd0);
    chk("reset_entry", {entry, entry_count, second_op, overflow}, 21'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    mon_en = 1'b1;

    // Digit entry and backspace
    press(1); press(2); press(3);
    chk("t1_entry", entry, 16'h0123);
    chk("t1_count", entry_count, 3'd3);
    press(13);
    chk("t1_bksp_entry", entry, 16'h0012);
    chk("t1_bksp_count", entry_count, 3'd2);
    press(12);

    // Leading zeros
    press(0); press(0); press(7);
    chk("t2_entry", entry, 16'h0007);
    chk("t2_count", entry_count, 3'd1);
    press(12);

    // Overflow on fifth digit
    press(1); press(2); press(3); press(4); press(5);
    chk("t3_entry", entry, 16'h1234);
    chk("t3_ovf", overflow, 1'b1);
    idle(1);
    chk("t3_ovf_drop", overflow, 1'b0);
    press(12);

    // Issue held while not ready
    press(1); press(2); press(10); press(3); press(14);
    for (int i = 0; i < 10; i++) begin
      chk("t4_valid_hold", calc_valid, 1'b1);
      idle(1);
    end
    chk("t4_a", operand_a, 16'h0012);
    chk("t4_b", operand_b, 16'h0003);
    chk("t4_op", op, 2'b00);
    accept(0);
    chk("t4_valid_drop", calc_valid, 1'b0);
    chk("t4_state_a", {second_op, entry_count}, 4'd0);

    // Operator replacement rules
    press(9); press(11); press(15); press(4); press(14);
    chk("t5_mul", op, 2'b10);
    accept(0);
    press(9); press(10); press(4); press(11);
    chk("t5_op_kept", op, 2'b00);
    chk("t5_second", second_op, 1'b1);
    press(12);
    chk("t5_clr_b", {second_op, operand_a, op}, 19'd0);

    // Randomized sessions
    for (int n = 0; n < 400; n++) begin
      if (mmode == 2) begin
        accept($urandom_range(0, 5));
      end else if (mmode == 1 && $urandom_range(0, 5) == 0) begin
        calc_ready = 1'b1;
        press(14);
        @(posedge clock); #1;
        calc_ready = 1'b0;
        mval = 0;
        mmode = 0;
      end else begin
        if ($urandom_range(0, 2) == 0) k = $urandom_range(0, 15);
        else k = $urandom_range(0, 9);
        press(k);
        idle($urandom_range(0, 2));
      end
    end
    if (mmode == 2) accept(1);

    // Reset mid-handshake
    press(12);
    press(5); press(10); press(6); press(14);
    idle(2);
    chk("t6_valid_before", calc_valid, 1'b1);
    @(negedge clock); #2;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_valid_async", calc_valid, 1'b0);
    chk("t6_outputs", {operand_a, operand_b, op, entry, entry_count, second_op, overflow}, 55'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    snap_q.delete();
    txn_q.delete();
    mval = 0; mmode = 0; ma = 0; mop = 0; mb = 0;
    @(posedge clock); #1;
    mon_en = 1'b1;
    press(8);
    idle(2);

    chk("snap_q_empty", snap_q.size(), 0);
    chk("txn_q_empty", txn_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
